// File: rtl/tft_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tft_bus_arbiter
// Purpose  : Registered-grant arbiter that gives one drawing requester the
//            shared tft_spi transmitter, with a drain phase and a byte counter.
// Options  : TFT_ARB_ROUND_ROBIN_EN selects round-robin arbitration
//            (default build uses fixed priority, index 0 highest).
// Revision : 1.0 - initial release
// ============================================================================
module tft_bus_arbiter #(
   parameter int N_REQ = 3
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [N_REQ-1:0]   i_req,
   input  logic [8*N_REQ-1:0] i_req_data,
   input  logic [N_REQ-1:0]   i_req_dc,
   input  logic [N_REQ-1:0]   i_req_transmit,
   input  logic               i_spi_busy,
   output logic [N_REQ-1:0]   o_grant,
   output logic [7:0]         o_spi_data,
   output logic               o_spi_dc,
   output logic               o_spi_transmit,
   output logic [15:0]        o_byte_count,
   output logic               o_arb_busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [N_REQ-1:0] c_one = N_REQ'(1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [N_REQ-1:0]   r_grant;
   logic [N_REQ-1:0]   w_grant_nxt;
   logic [N_REQ-1:0]   w_win;
   logic [15:0]        r_byte_count;
   logic [7:0]         w_owner_data;
   logic               w_owner_dc;
   logic               w_owner_tx;
   logic               w_owner_req;
   logic               w_load;
   logic               w_accept;

`ifdef TFT_ARB_ROUND_ROBIN_EN
   localparam int IW = $clog2(N_REQ);

   logic [IW-1:0] r_last;
   logic [IW-1:0] w_win_idx;
   logic          w_found;

   function automatic logic [IW-1:0] f_wrap(input int v);
      return IW'(v % N_REQ);
   endfunction

   // Search upward starting just past the previous owner.
   always_comb begin
      w_found   = 1'b0;
      w_win_idx = r_last;
      for (int i = 1; i <= N_REQ; i++) begin
         if (!w_found && i_req[f_wrap(int'(r_last) + i)]) begin
            w_found   = 1'b1;
            w_win_idx = f_wrap(int'(r_last) + i);
         end
      end
      w_win = w_found ? (c_one << w_win_idx) : '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_last <= IW'(N_REQ - 1);
      else if (w_load)
         r_last <= w_win_idx;
   end
`else
   // Isolate the lowest set request bit.
   assign w_win = i_req & (~i_req + c_one);
`endif

   always_comb begin
      w_owner_data = '0;
      w_owner_dc   = 1'b0;
      w_owner_tx   = 1'b0;
      w_owner_req  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (r_grant[i]) begin
            w_owner_data = w_owner_data | i_req_data[8*i +: 8];
            w_owner_dc   = w_owner_dc   | i_req_dc[i];
            w_owner_tx   = w_owner_tx   | i_req_transmit[i];
            w_owner_req  = w_owner_req  | i_req[i];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|i_req) begin
               w_state_nxt = ST_GRANT;
               w_grant_nxt = w_win;
               w_load      = 1'b1;
            end
         end
         ST_GRANT: begin
            if (!w_owner_req)
               w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!i_spi_busy) begin
               w_state_nxt = ST_IDLE;
               w_grant_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
      end
   end

   // A strobe coinciding with the owner's req falling is suppressed.
   assign o_spi_transmit = (r_state == ST_GRANT) && w_owner_tx && w_owner_req;
   assign w_accept       = o_spi_transmit && !i_spi_busy;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_byte_count <= '0;
      else if (w_load)
         r_byte_count <= '0;
      else if (w_accept && (r_byte_count != 16'hFFFF))
         r_byte_count <= r_byte_count + 16'd1;
   end

   assign o_grant      = r_grant;
   assign o_spi_data   = w_owner_data;
   assign o_spi_dc     = w_owner_dc;
   assign o_byte_count = r_byte_count;
   assign o_arb_busy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tft_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tft_bus_arbiter
// Purpose  : Directed self-checking bench for tft_bus_arbiter (N_REQ = 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tft_bus_arbiter;

   localparam int N_REQ = 3;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [N_REQ-1:0]   req = '0;
   logic [8*N_REQ-1:0] req_data = '0;
   logic [N_REQ-1:0]   req_dc = '0;
   logic [N_REQ-1:0]   req_transmit = '0;
   logic               spi_busy = 1'b0;
   logic [N_REQ-1:0]   grant;
   logic [7:0]         spi_data;
   logic               spi_dc;
   logic               spi_transmit;
   logic [15:0]        byte_count;
   logic               arb_busy;

   int n_cmp = 0;
   int n_bad = 0;

   tft_bus_arbiter #(.N_REQ(N_REQ)) u_dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_req          (req),
      .i_req_data     (req_data),
      .i_req_dc       (req_dc),
      .i_req_transmit (req_transmit),
      .i_spi_busy     (spi_busy),
      .o_grant        (grant),
      .o_spi_data     (spi_data),
      .o_spi_dc       (spi_dc),
      .o_spi_transmit (spi_transmit),
      .o_byte_count   (byte_count),
      .o_arb_busy     (arb_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [N_REQ-1:0] exp_seq [4];
      int               n_rounds;
      logic             reraise;

      // Reset state
      #3;
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_count", 32'(byte_count), 32'h0);
      check("rst_busy", 32'(arb_busy), 32'h0);
      check("rst_data", 32'(spi_data), 32'h0);
      check("rst_tx", 32'(spi_transmit), 32'h0);
      #10 rst_n = 1'b1;
      step();

      // Single requester, two bytes pass through
      req = 3'b010;
      step();
      check("t1_grant", 32'(grant), 32'h2);
      check("t1_busy", 32'(arb_busy), 32'h1);
      check("t1_count0", 32'(byte_count), 32'h0);
      req_data[15:8] = 8'h2A;
      req_dc         = 3'b010;
      req_transmit   = 3'b010;
      #1;
      check("t1_data0", 32'(spi_data), 32'h2A);
      check("t1_dc0", 32'(spi_dc), 32'h1);
      check("t1_tx0", 32'(spi_transmit), 32'h1);
      step();
      req_data[15:8] = 8'h2C;
      req_dc         = 3'b000;
      #1;
      check("t1_data1", 32'(spi_data), 32'h2C);
      check("t1_dc1", 32'(spi_dc), 32'h0);
      check("t1_count1", 32'(byte_count), 32'h1);
      step();
      req_transmit = 3'b000;
      #1;
      check("t1_count2", 32'(byte_count), 32'h2);

      // Non-owner strobe is dropped
      req_transmit    = 3'b100;
      req_data[23:16] = 8'hFF;
      #1;
      check("nonown_tx", 32'(spi_transmit), 32'h0);
      check("nonown_data", 32'(spi_data), 32'h2C);
      step();
      req_transmit = 3'b000;
      #1;
      check("nonown_count", 32'(byte_count), 32'h2);

      // Strobe coinciding with req falling is suppressed, then drain
      req          = 3'b000;
      req_transmit = 3'b010;
      #1;
      check("fall_tx", 32'(spi_transmit), 32'h0);
      step();
      req_transmit = 3'b000;
      #1;
      check("drain_grant", 32'(grant), 32'h2);
      check("drain_busy", 32'(arb_busy), 32'h1);
      step();
      check("idle_grant", 32'(grant), 32'h0);
      check("idle_busy", 32'(arb_busy), 32'h0);
      check("idle_count", 32'(byte_count), 32'h2);

      // Three-way contention; owner releases each round
`ifdef TFT_ARB_ROUND_ROBIN_EN
      exp_seq  = '{3'b100, 3'b001, 3'b010, 3'b100};
      n_rounds = 4;
      reraise  = 1'b1;
`else
      exp_seq  = '{3'b001, 3'b010, 3'b100, 3'b000};
      n_rounds = 3;
      reraise  = 1'b0;
`endif
      req = 3'b111;
      for (int r = 0; r < n_rounds; r++) begin
         step();
         check($sformatf("arb_grant%0d", r), 32'(grant), 32'(exp_seq[r]));
         req = req & ~exp_seq[r];
         step();
         check($sformatf("arb_drain%0d", r), 32'(grant), 32'(exp_seq[r]));
         step();
         check($sformatf("arb_idle%0d", r), 32'(grant), 32'h0);
         if (reraise)
            req = req | exp_seq[r];
      end
      req = 3'b000;
      step();

      // Drain held while the transmitter is busy
      req = 3'b001;
      step();
      check("t3_grant", 32'(grant), 32'h1);
      check("t3_count0", 32'(byte_count), 32'h0);
      req_transmit = 3'b001;
      spi_busy     = 1'b1;
      #1;
      check("t3_tx_busy", 32'(spi_transmit), 32'h1);
      step();
      check("t3_count_busy", 32'(byte_count), 32'h0);
      req = 3'b000;
      step();
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t3_hold_grant%0d", i), 32'(grant), 32'h1);
         check($sformatf("t3_hold_tx%0d", i), 32'(spi_transmit), 32'h0);
         if (i == 4)
            spi_busy = 1'b0;
         step();
      end
      check("t3_release", 32'(grant), 32'h0);
      check("t3_release_busy", 32'(arb_busy), 32'h0);
      req_transmit = 3'b000;
      step();

      // Asynchronous reset mid-grant with byte_count = 7
      req = 3'b100;
      step();
      req_transmit    = 3'b100;
      req_data[23:16] = 8'h5A;
      repeat (7) step();
      #1;
      check("t4_count7", 32'(byte_count), 32'h7);
      check("t4_tx", 32'(spi_transmit), 32'h1);
      check("t4_data", 32'(spi_data), 32'h5A);
      #1 rst_n = 1'b0;
      #1;
      check("t4_rst_grant", 32'(grant), 32'h0);
      check("t4_rst_count", 32'(byte_count), 32'h0);
      check("t4_rst_data", 32'(spi_data), 32'h0);
      check("t4_rst_tx", 32'(spi_transmit), 32'h0);
      check("t4_rst_busy", 32'(arb_busy), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tft_bus_arbiter.md
# tft_bus_arbiter

Grants exclusive use of the shared `tft_spi` transmitter to one of `N_REQ` drawing requesters (`tft_init`, `scene_exhibitor`, `player`, and future overlays). It replaces ad-hoc enable-priority muxing in the top level with a registered grant, a drain phase, and a byte counter. It sits between the requester outputs and the transmitter inputs. Requester handshakes (`data`/`dc`/`transmit` against `tft_busy`) pass through unchanged.

## Interface
- `N_REQ`, 3: number of requesters (2..8); index 0 is the highest fixed priority.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-low reset.
- `req` input N_REQ: per-requester request; held high for the entire drawing sequence.
- `req_data` input 8*N_REQ: byte from requester i on bits [8i+7:8i].
- `req_dc` input N_REQ: data/command flag per requester.
- `req_transmit` input N_REQ: transmit strobe per requester.
- `spi_busy` input 1: `busy` from `tft_spi`.
- `grant` output N_REQ: one-hot owner, registered.
- `spi_data` output 8: byte to `tft_spi`.
- `spi_dc` output 1: dc to `tft_spi`.
- `spi_transmit` output 1: transmit strobe to `tft_spi`.
- `byte_count` output 16: bytes forwarded during the current or most recent grant; saturates at 0xFFFF.
- `arb_busy` output 1: high in GRANT or DRAIN.

## Operation
- States: IDLE, GRANT, DRAIN.
- **IDLE**
  - If `req` != 0, select a winner, load the one-hot `grant`, clear `byte_count`, and go to GRANT.
  - If `req` == 0, stay in IDLE with `grant` = 0.
- **GRANT**
  - `spi_data`, `spi_dc`, `spi_transmit` = the owner's inputs, muxed combinationally from registered `grant`.
  - `spi_transmit` is additionally gated by `req[owner]`.
  - `byte_count` increments on each cycle where `spi_transmit` && !`spi_busy`.
  - When `req[owner]` falls, go to DRAIN.
- **DRAIN**
  - `grant` is held; `spi_transmit` is forced to 0.
  - When `spi_busy` == 0, clear `grant` and go to IDLE.
- Strobes from non-owners are dropped, never queued.
- Other requests raised during GRANT or DRAIN wait; there is no preemption.
- When `grant` == 0, outputs are `spi_data` = 0, `spi_dc` = 0, `spi_transmit` = 0.
- Reset values: state IDLE, `grant` 0, `byte_count` 0, `arb_busy` 0, all `spi_*` outputs 0.
- Reset asserted mid-transfer drops ownership immediately. Resetting `tft_spi` is the top level's job.

## Timing
- Grant latency: `req` rising in IDLE at edge k gives `grant` at edge k+1. A requester's first `transmit` is honoured from cycle k+1.
- Pass-through adds zero cycles of data latency.
- Release path: `req` falling at edge k gives DRAIN at k+1. IDLE is reached at the first edge after that at which `spi_busy` == 0, no earlier than k+2.
- There is at least one IDLE cycle between consecutive grants.
- `req` falling in the same cycle as `transmit`: that strobe is suppressed.
- `req` dropping and re-rising during DRAIN: the requester is treated as a new request in IDLE.
- `byte_count` updates one cycle after the accepted strobe. It stays at 0xFFFF once saturated.

## Configuration
- `TFT_ARB_ROUND_ROBIN_EN` defined: winner is the first set `req` bit searching upward from (last owner + 1) mod `N_REQ`. The last-owner pointer resets to `N_REQ`-1, so index 0 wins the first tie.
- Undefined: fixed priority, lowest set index wins. No pointer register exists.

## Test plan
- Reset then `req`=3'b010: `grant`=3'b010 one cycle later. Two strobes of 0x2A/0x2C pass to `spi_data` unchanged; `byte_count`=2.
- `req`=3'b111 from IDLE, fixed priority: `grant`=3'b001. Drop `req[0]`: `grant`=3'b010 after DRAIN plus one IDLE cycle.
- Same stimulus with `TFT_ARB_ROUND_ROBIN_EN`: grant order 001→010→100→001 across four release cycles.
- Owner drops `req` while `spi_busy`=1 for 5 cycles: `grant` held 5 cycles and `spi_transmit`=0 throughout. IDLE is reached the cycle after `spi_busy` falls.
- Non-owner pulses `req_transmit` with 0xFF: `spi_transmit` stays 0 and `byte_count` is unchanged.
- Assert `rst`=0 mid-GRANT with `byte_count`=7: `grant`, `byte_count`, and `spi_*` go to 0 asynchronously without waiting for a clock edge.
